dir_validator: RTL and testbench

Direction validator for the Othello move pipeline. On a start pulse from the new-move controller it walks the bordered 10x10 board memory from a candidate square along one signed step (±1, ±10, optionally ±9/±11). It reports whether the walk encloses at least one opponent disc with one of the mover's discs. It is the responder end of the controller's `ld`/`enable`/`s_done`/`dir_status` handshake. It owns one read/write port into the board RAM.

---
 rtl/othello_pkg.sv | 27 ++
 rtl/dir_validator.sv | 171 +++++++++++++++++
 tb/tb_dir_validator.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/othello_pkg.sv
// Shared Othello move-pipeline definitions: cell codes, board geometry,
// step constants and the direction-validator state encoding.
package othello_pkg;

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  localparam int BOARD_W     = 10;
  localparam int BOARD_CELLS = BOARD_W * BOARD_W;
  localparam int ADDR_W      = 7;

  localparam logic signed [4:0] STEP_U = -5'sd10;
  localparam logic signed [4:0] STEP_D =  5'sd10;
  localparam logic signed [4:0] STEP_L = -5'sd1;
  localparam logic signed [4:0] STEP_R =  5'sd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_FLIP,
    ST_DONE
  } dv_state_e;

endpackage

// File: rtl/dir_validator.sv
// Walks one direction from a candidate square and reports whether it encloses
// opponent discs. Define DIR_VALIDATOR_FLIP_EN to build the run-flipping write-back.
module dir_validator #(
  parameter int ADDR_W      = othello_pkg::ADDR_W,
  parameter int BOARD_CELLS = othello_pkg::BOARD_CELLS,
  parameter int MAX_RUN     = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld,
  input  logic              enable,
  input  logic [4:0]        step_in,
  input  logic [ADDR_W-1:0] e_addr_in,
  input  logic [1:0]        player_in,
  input  logic              flip_in,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [1:0]        mem_rd_data_i,
  output logic              mem_wr_en_o,
  output logic [1:0]        mem_wr_data_o,
  output logic              busy_o,
  output logic              s_done_o,
  output logic              dir_status_o
);
  import othello_pkg::*;

  localparam int RUN_W = $clog2(MAX_RUN + 1);

  dv_state_e         state_q;
  logic [ADDR_W-1:0] cur_q, org_q, addr_q;
  logic [4:0]        step_q;
  logic [1:0]        player_q, wr_data_q;
  logic              busy_q, done_q, status_q, wr_en_q;
  logic [RUN_W-1:0]  run_q;

  logic [4:0]        step_eff;
  logic [ADDR_W-1:0] org_eff, start_addr, step_x, fwd_addr;
  logic [1:0]        opp;
  logic              player_ok;

`ifdef DIR_VALIDATOR_FLIP_EN
  logic              flip_q;
  logic [ADDR_W-1:0] back_addr;
`else
  logic              unused_flip;
  assign unused_flip = flip_in;
`endif

  // A load in the same cycle as enable must steer the very first address.
  always_comb begin
    step_eff   = ld ? step_in : step_q;
    org_eff    = ld ? e_addr_in : org_q;
    start_addr = org_eff + {{(ADDR_W-5){step_eff[4]}}, step_eff};
    step_x     = {{(ADDR_W-5){step_q[4]}}, step_q};
    fwd_addr   = cur_q + step_x;
`ifdef DIR_VALIDATOR_FLIP_EN
    back_addr  = cur_q - step_x;
`endif
    opp        = player_q ^ CELL_BORDER;
    player_ok  = (player_q == CELL_BLACK) || (player_q == CELL_WHITE);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cur_q     <= '0;
      org_q     <= '0;
      addr_q    <= '0;
      step_q    <= '0;
      player_q  <= CELL_EMPTY;
      wr_data_q <= CELL_EMPTY;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      status_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      run_q     <= '0;
`ifdef DIR_VALIDATOR_FLIP_EN
      flip_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ld) begin
            step_q   <= step_in;
            org_q    <= e_addr_in;
            player_q <= player_in;
`ifdef DIR_VALIDATOR_FLIP_EN
            flip_q   <= flip_in;
`endif
          end
          if (enable) begin
            cur_q    <= start_addr;
            run_q    <= '0;
            busy_q   <= 1'b1;
            status_q <= 1'b0;
            state_q  <= ST_READ;
            if (int'(start_addr) < BOARD_CELLS) addr_q <= start_addr;
          end
        end
        ST_READ: begin
          // Off-board addresses are treated as border without touching the RAM.
          if (int'(cur_q) >= BOARD_CELLS) begin
            done_q   <= 1'b1;
            status_q <= 1'b0;
            state_q  <= ST_DONE;
          end else begin
            state_q  <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (mem_rd_data_i == opp && int'(run_q) < MAX_RUN) begin
            run_q   <= run_q + 1'b1;
            cur_q   <= fwd_addr;
            state_q <= ST_READ;
            if (int'(fwd_addr) < BOARD_CELLS) addr_q <= fwd_addr;
          end else if (mem_rd_data_i == player_q && run_q != '0 && player_ok) begin
`ifdef DIR_VALIDATOR_FLIP_EN
            if (flip_q) begin
              cur_q     <= back_addr;
              addr_q    <= back_addr;
              wr_en_q   <= 1'b1;
              wr_data_q <= player_q;
              state_q   <= ST_FLIP;
            end else begin
              done_q    <= 1'b1;
              status_q  <= 1'b1;
              state_q   <= ST_DONE;
            end
`else
            done_q   <= 1'b1;
            status_q <= 1'b1;
            state_q  <= ST_DONE;
`endif
          end else begin
            done_q   <= 1'b1;
            status_q <= 1'b0;
            state_q  <= ST_DONE;
          end
        end
`ifdef DIR_VALIDATOR_FLIP_EN
        ST_FLIP: begin
          if (run_q == RUN_W'(1)) begin
            wr_en_q   <= 1'b0;
            wr_data_q <= CELL_EMPTY;
            done_q    <= 1'b1;
            status_q  <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            run_q  <= run_q - 1'b1;
            cur_q  <= back_addr;
            addr_q <= back_addr;
          end
        end
`endif
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr_o    = addr_q;
  assign mem_wr_en_o   = wr_en_q;
  assign mem_wr_data_o = wr_data_q;
  assign busy_o        = busy_q;
  assign s_done_o      = done_q;
  assign dir_status_o  = status_q;

endmodule

// File: tb/tb_dir_validator.sv
// Directed bench for dir_validator: a vector table of straight-line walks on a
// modelled board RAM, plus reset-mid-walk, busy-enable and ld-then-enable sequences.
module tb_dir_validator;
  import othello_pkg::*;

`ifdef DIR_VALIDATOR_FLIP_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif

  logic       clock = 1'b0, reset = 1'b0, ld = 1'b0, enable = 1'b0, flip_in = 1'b0;
  logic [4:0] step_in = '0;
  logic [6:0] e_addr_in = '0;
  logic [1:0] player_in = '0;
  logic [6:0] mem_addr_o;
  logic [1:0] mem_rd_data_i, mem_wr_data_o;
  logic       mem_wr_en_o, busy_o, s_done_o, dir_status_o;

  dir_validator dut (
    .clock(clock), .reset(reset), .ld(ld), .enable(enable),
    .step_in(step_in), .e_addr_in(e_addr_in), .player_in(player_in), .flip_in(flip_in),
    .mem_addr_o(mem_addr_o), .mem_rd_data_i(mem_rd_data_i),
    .mem_wr_en_o(mem_wr_en_o), .mem_wr_data_o(mem_wr_data_o),
    .busy_o(busy_o), .s_done_o(s_done_o), .dir_status_o(dir_status_o)
  );

  always #5 clock = ~clock;

  // Board RAM model: registered read, one-cycle latency; bulk load from board_img.
  logic [1:0] mem [0:127];
  logic [1:0] board_img [0:127];
  logic       ld_board = 1'b0;
  always @(posedge clock) begin
    mem_rd_data_i <= mem[mem_addr_o];
    if (ld_board) begin
      for (int i = 0; i < 128; i++) mem[i] <= board_img[i];
    end else if (mem_wr_en_o) begin
      mem[mem_addr_o] <= mem_wr_data_o;
    end
  end

  typedef struct {
    string      nm;
    int         org, step;
    logic [1:0] pl;
    logic       fl;
    int         nrun;
    logic [1:0] rv;
    bit         tset;
    logic [1:0] tv;
    int         ecyc;
    int         est;
    int         ewr;
    int         ca;
    logic [1:0] cv;
  } vec_t;

  int n_vec = 0, n_bad = 0;
  vec_t vecs[13];

  function automatic vec_t mk(string nm, int org, int step, logic [1:0] pl, logic fl,
                              int nrun, logic [1:0] rv, bit tset, logic [1:0] tv,
                              int ecyc, int est, int ewr, int ca, logic [1:0] cv);
    vec_t v;
    v.nm = nm; v.org = org; v.step = step; v.pl = pl; v.fl = fl;
    v.nrun = nrun; v.rv = rv; v.tset = tset; v.tv = tv;
    v.ecyc = ecyc; v.est = est; v.ewr = ewr; v.ca = ca; v.cv = cv;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic setup_board(input vec_t v);
    for (int i = 0; i < 128; i++) begin
      if (i >= 100 || i / 10 == 0 || i / 10 == 9 || i % 10 == 0 || i % 10 == 9)
        board_img[i] = CELL_BORDER;
      else
        board_img[i] = CELL_EMPTY;
    end
    for (int j = 0; j < v.nrun; j++) board_img[v.org + v.step * (j + 1)] = v.rv;
    if (v.tset) board_img[v.org + v.step * (v.nrun + 1)] = v.tv;
    @(negedge clock); ld_board = 1'b1;
    @(negedge clock); ld_board = 1'b0;
  endtask

  // Drives ld+enable for edge 0; returns at the negedge of cycle 1.
  task automatic launch(input vec_t v);
    e_addr_in = v.org[6:0]; step_in = v.step[4:0]; player_in = v.pl; flip_in = v.fl;
    ld = 1'b1; enable = 1'b1;
    @(negedge clock);
    ld = 1'b0; enable = 1'b0;
  endtask

  // Starts sampling in cycle 1; follows the walk to s_done_o and one cycle beyond.
  task automatic observe(input vec_t v);
    int cyc = 1, dc = 0, nwr = 0, st = 0, bz = 1, oor = 0;
    int wa[8], wc[8], wd[8];
    while (dc == 0 && cyc <= 60) begin
      if (!busy_o) bz = 0;
      if (int'(mem_addr_o) >= 100) oor = 1;
      if (mem_wr_en_o && nwr < 8) begin
        wa[nwr] = int'(mem_addr_o); wc[nwr] = cyc; wd[nwr] = int'(mem_wr_data_o); nwr++;
      end
      if (s_done_o) begin
        dc = cyc; st = int'(dir_status_o);
      end else begin
        @(negedge clock); cyc++;
      end
    end
    check({v.nm, " done cycle"}, dc, v.ecyc);
    check({v.nm, " status"}, st, v.est);
    check({v.nm, " write count"}, nwr, v.ewr);
    check({v.nm, " busy held"}, bz, 1);
    check({v.nm, " off-board addr"}, oor, 0);
    for (int j = 0; j < nwr; j++) begin
      check({v.nm, " write addr"}, wa[j], v.org + v.step * (v.nrun - j));
      check({v.nm, " write cycle"}, wc[j], 2 * v.nrun + 3 + j);
      check({v.nm, " write data"}, wd[j], int'(v.pl));
    end
    @(negedge clock);
    check({v.nm, " busy after"}, int'(busy_o), 0);
    check({v.nm, " done after"}, int'(s_done_o), 0);
    check({v.nm, " status held"}, int'(dir_status_o), v.est);
    check({v.nm, " cell"}, int'(mem[v.ca]), int'(v.cv));
  endtask

  initial begin
    int ndone, fdc, fst, nbz;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("rst busy", int'(busy_o), 0);
    check("rst done", int'(s_done_o), 0);
    check("rst status", int'(dir_status_o), 0);
    check("rst wr_en", int'(mem_wr_en_o), 0);
    check("rst addr", int'(mem_addr_o), 0);
    check("rst wr_data", int'(mem_wr_data_o), 0);
    reset = 1'b1;
    @(negedge clock);

    //            name      org step pl     fl nrun rv     tset tv     cyc         st wr       chk  cv
    vecs[0]  = mk("r1",      44,   1, 2'b01, 0, 1, 2'b10, 1, 2'b01,  5,          1, 0,       45, 2'b10);
    vecs[1]  = mk("up_empty",44, -10, 2'b01, 0, 0, 2'b00, 1, 2'b00,  3,          0, 0,       34, 2'b00);
    vecs[2]  = mk("l_border",41,  -1, 2'b01, 0, 0, 2'b00, 1, 2'b11,  3,          0, 0,       40, 2'b11);
    vecs[3]  = mk("off_brd", 95,  10, 2'b01, 0, 0, 2'b00, 0, 2'b00,  2,          0, 0,       95, 2'b11);
    vecs[4]  = mk("flip3",   44,   1, 2'b01, 1, 3, 2'b10, 1, 2'b01, FE ? 12 : 9, 1, FE ? 3 : 0,
                  45, FE ? 2'b01 : 2'b10);
    vecs[5]  = mk("run0",    44,   1, 2'b01, 0, 0, 2'b00, 1, 2'b01,  3,          0, 0,       45, 2'b01);
    vecs[6]  = mk("overrun", 44,   1, 2'b01, 0, 7, 2'b10, 0, 2'b00, 15,          0, 0,       51, 2'b10);
    vecs[7]  = mk("run6",    44,   1, 2'b01, 0, 6, 2'b10, 1, 2'b01, 15,          1, 0,       50, 2'b10);
    vecs[8]  = mk("bad_pl",  44,   1, 2'b11, 0, 0, 2'b00, 0, 2'b00, 11,          0, 0,       49, 2'b11);
    vecs[9]  = mk("diag",    55, -11, 2'b01, 0, 1, 2'b10, 1, 2'b01,  5,          1, 0,       44, 2'b10);
    vecs[10] = mk("white",   44,  10, 2'b10, 0, 2, 2'b01, 1, 2'b10,  7,          1, 0,       64, 2'b01);
    vecs[11] = mk("flip_r0", 44,   1, 2'b01, 1, 0, 2'b00, 1, 2'b01,  3,          0, 0,       45, 2'b01);
    vecs[12] = mk("flip1",   44,  -1, 2'b10, 1, 1, 2'b01, 1, 2'b10, FE ? 6 : 5,  1, FE ? 1 : 0,
                  43, FE ? 2'b10 : 2'b01);

    for (int i = 0; i < 13; i++) begin
      setup_board(vecs[i]);
      launch(vecs[i]);
      observe(vecs[i]);
    end

    // Reset asserted in cycle 4 of a long walk aborts it silently.
    setup_board(vecs[7]);
    launch(vecs[7]);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("midrst busy", int'(busy_o), 0);
    check("midrst done", int'(s_done_o), 0);
    check("midrst status", int'(dir_status_o), 0);
    check("midrst wr_en", int'(mem_wr_en_o), 0);
    reset = 1'b1;
    ndone = 0; nbz = 0;
    repeat (20) begin
      @(negedge clock);
      if (s_done_o) ndone++;
      if (busy_o) nbz++;
    end
    check("midrst late done", ndone, 0);
    check("midrst late busy", nbz, 0);

    // ld/enable in cycle 2 of a walk must not disturb it.
    setup_board(vecs[0]);
    launch(vecs[0]);
    @(negedge clock);
    e_addr_in = 7'd41; step_in = 5'h1f; player_in = 2'b10; ld = 1'b1; enable = 1'b1;
    @(negedge clock);
    ld = 1'b0; enable = 1'b0;
    ndone = 0; fdc = 0; fst = 0;
    for (int c = 3; c <= 14; c++) begin
      if (s_done_o) begin
        ndone++;
        if (fdc == 0) begin fdc = c; fst = int'(dir_status_o); end
      end
      @(negedge clock);
    end
    check("busy_en done cycle", fdc, 5);
    check("busy_en done count", ndone, 1);
    check("busy_en status", fst, 1);
    check("busy_en status held", int'(dir_status_o), 1);

    // ld alone, then enable with junk inputs: captured values drive the walk,
    // and the held status clears when the walk is accepted.
    setup_board(vecs[1]);
    e_addr_in = 7'd44; step_in = 5'h16; player_in = 2'b01; flip_in = 1'b0; ld = 1'b1;
    @(negedge clock);
    ld = 1'b0; e_addr_in = 7'd95; step_in = 5'd10; player_in = 2'b10; enable = 1'b1;
    @(negedge clock);
    enable = 1'b0;
    check("ld_first status clr", int'(dir_status_o), 0);
    check("ld_first busy", int'(busy_o), 1);
    observe(vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
